sdram_arbiter: RTL and testbench

- Slot scheduler in front of the single-port SDRAM core, on the same `clk` as the core's state machine.
- Shares fixed-length SDRAM access slots between three requesters: ROM loader, CPU and PPU.
- Drives one registered command (address / write / read / data) per slot and routes read data and completion acks back to the owner.
- Guarantees an idle (auto-refresh) slot at a bounded interval.

---
 rtl/sdram_pkg.sv | 16 +
 rtl/sdram_rr2.sv | 24 ++
 rtl/sdram_arbiter.sv | 151 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared constants and owner encoding for the SDRAM slot arbiter and its helpers.
package sdram_pkg;

    localparam int unsigned SDRAM_ADDR_W    = 25;
    localparam int unsigned DEF_SLOT_LEN    = 8;
    localparam int unsigned DEF_RD_LAT      = 5;
    localparam int unsigned DEF_REFRESH_MAX = 64;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_DL   = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_PPU  = 2'd3
    } owner_t;

endpackage

// File: rtl/sdram_rr2.sv
// Two-input round-robin picker: on a tie, picks the input not granted last.
module sdram_rr2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic pick1_c
);

    logic last1;

    // Pointer starts at input 1 so input 0 wins the first tie.
    assign pick1_c = req1 & (~req0 | ~last1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last1 <= 1'b1;
        end else if (advance) begin
            last1 <= pick1_c;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Fixed-length slot scheduler sharing the SDRAM core between loader, CPU and PPU,
// with a forced idle (refresh) slot after a bounded run of busy slots.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned SLOT_LEN    = DEF_SLOT_LEN,
    parameter int unsigned RD_LAT      = DEF_RD_LAT,
    parameter int unsigned REFRESH_MAX = DEF_REFRESH_MAX,
    parameter int unsigned ADDR_W      = SDRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dl_req,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_din,
    output logic              dl_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    input  logic              ppu_req,
    input  logic              ppu_we,
    input  logic [ADDR_W-1:0] ppu_addr,
    input  logic [7:0]        ppu_din,
    output logic [7:0]        ppu_dout,
    output logic              ppu_ack,
    output logic              mem_start,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    output logic [1:0]        mem_owner
);

    localparam int unsigned PHASE_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int unsigned BUSY_W  = $clog2(REFRESH_MAX + 1);
    localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(SLOT_LEN - 1);
    localparam logic [PHASE_W-1:0] RD_PH   = PHASE_W'(RD_LAT);
    localparam logic [BUSY_W-1:0]  BUSY_MAX = BUSY_W'(REFRESH_MAX);

    logic [PHASE_W-1:0] phase;
    logic [BUSY_W-1:0]  busy_cnt;
    logic               slot_end_c;
    logic               force_idle_c;
    logic               rd_phase_c;
    logic               rr_pick_ppu_c;
    logic               rr_advance_c;
    owner_t             grant_c;

    assign slot_end_c   = (phase == LAST_PH);
    assign force_idle_c = (busy_cnt == BUSY_MAX);
    assign rd_phase_c   = (phase == RD_PH);

    always_comb begin
        grant_c = OWN_IDLE;
        if (force_idle_c) begin
            grant_c = OWN_IDLE;
        end else if (dl_req) begin
            grant_c = OWN_DL;
        end else if (cpu_req | ppu_req) begin
            grant_c = rr_pick_ppu_c ? OWN_PPU : OWN_CPU;
        end
    end

    assign rr_advance_c = slot_end_c & ((grant_c == OWN_CPU) | (grant_c == OWN_PPU));

    sdram_rr2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req0    (cpu_req),
        .req1    (ppu_req),
        .advance (rr_advance_c),
        .pick1_c (rr_pick_ppu_c)
    );

    // Reset parks the counter at the last phase so the first slot opens right after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase     <= LAST_PH;
            mem_start <= 1'b0;
        end else begin
            phase     <= slot_end_c ? '0 : phase + PHASE_W'(1);
            mem_start <= slot_end_c;
        end
    end

    // Slot command registers: loaded at the slot boundary, held for the whole slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_owner <= OWN_IDLE;
            mem_we    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            busy_cnt  <= '0;
        end else if (slot_end_c) begin
            mem_owner <= grant_c;
            busy_cnt  <= (grant_c == OWN_IDLE) ? '0
                       : (force_idle_c ? busy_cnt : busy_cnt + BUSY_W'(1));
            case (grant_c)
                OWN_DL: begin
                    mem_we   <= 1'b1;
                    mem_oe   <= 1'b0;
                    mem_addr <= dl_addr;
                    mem_din  <= dl_din;
                end
                OWN_CPU: begin
                    mem_we   <= cpu_we;
                    mem_oe   <= ~cpu_we;
                    mem_addr <= cpu_addr;
                    mem_din  <= cpu_din;
                end
                OWN_PPU: begin
                    mem_we   <= ppu_we;
                    mem_oe   <= ~ppu_we;
                    mem_addr <= ppu_addr;
                    mem_din  <= ppu_din;
                end
                default: begin
                    mem_we <= 1'b0;
                    mem_oe <= 1'b0;
                end
            endcase
        end
    end

    // Completion: ack one cycle after the read-data phase; read data lands with the ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_ack   <= 1'b0;
            cpu_ack  <= 1'b0;
            ppu_ack  <= 1'b0;
            cpu_dout <= '0;
            ppu_dout <= '0;
        end else begin
            dl_ack  <= rd_phase_c & (mem_owner == OWN_DL);
            cpu_ack <= rd_phase_c & (mem_owner == OWN_CPU);
            ppu_ack <= rd_phase_c & (mem_owner == OWN_PPU);
            if (rd_phase_c && mem_oe && (mem_owner == OWN_CPU)) begin
                cpu_dout <= mem_dout;
            end
            if (rd_phase_c && mem_oe && (mem_owner == OWN_PPU)) begin
                ppu_dout <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Slot-level scoreboard bench for sdram_arbiter: expected slot commands are queued at
// each grant decision and compared cycle by cycle as the slot plays out.
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int unsigned SL   = 8;
    localparam int unsigned RL   = 5;
    localparam int unsigned RMAX = 4;
    localparam int unsigned AW   = 25;

    logic          clk = 1'b0;
    logic          reset;
    logic          dl_req, dl_ack;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_din;
    logic          cpu_req, cpu_we, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din, cpu_dout;
    logic          ppu_req, ppu_we, ppu_ack;
    logic [AW-1:0] ppu_addr;
    logic [7:0]    ppu_din, ppu_dout;
    logic          mem_start, mem_we, mem_oe;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din, mem_dout;
    logic [1:0]    mem_owner;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .SLOT_LEN(SL), .RD_LAT(RL), .REFRESH_MAX(RMAX), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_din(ppu_din),
        .ppu_dout(ppu_dout), .ppu_ack(ppu_ack),
        .mem_start(mem_start), .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_owner(mem_owner)
    );

    typedef struct {
        logic [1:0]    owner;
        logic          we;
        logic          oe;
        logic [AW-1:0] addr;
        logic [7:0]    din;
    } slot_t;

    slot_t         exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            m_busy;
    logic          m_last_ppu;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_din, m_cpu_dout, m_ppu_dout;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy     = 0;
        m_last_ppu = 1'b1;
        m_addr     = '0;
        m_din      = '0;
        m_cpu_dout = '0;
        m_ppu_dout = '0;
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd"}, 64'({mem_owner, mem_we, mem_oe, mem_addr, mem_din}), 64'd0);
        check({tag, "_start"}, 64'(mem_start), 64'd0);
        check({tag, "_acks"}, 64'({dl_ack, cpu_ack, ppu_ack}), 64'd0);
        check({tag, "_douts"}, 64'({cpu_dout, ppu_dout}), 64'd0);
    endtask

    // Called just before a slot boundary edge; plays out one full slot.
    task automatic run_slot(input logic dl, input logic cr, input logic cw,
                            input logic [AW-1:0] ca, input logic [7:0] cd,
                            input logic pr, input logic pw,
                            input logic [AW-1:0] pa, input logic [7:0] pd,
                            input logic [7:0] rdata);
        slot_t e, cur;
        logic [2:0] ack_exp;
        dl_req = dl; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_din = cd;
        ppu_req = pr; ppu_we = pw; ppu_addr = pa; ppu_din = pd;

        e.owner = OWN_IDLE;
        if (m_busy == int'(RMAX))  e.owner = OWN_IDLE;
        else if (dl)               e.owner = OWN_DL;
        else if (cr && pr)         e.owner = m_last_ppu ? OWN_CPU : OWN_PPU;
        else if (cr)               e.owner = OWN_CPU;
        else if (pr)               e.owner = OWN_PPU;
        case (e.owner)
            OWN_DL:  begin e.we = 1'b1; e.oe = 1'b0; m_addr = dl_addr; m_din = dl_din; end
            OWN_CPU: begin e.we = cw; e.oe = ~cw; m_addr = ca; m_din = cd; m_last_ppu = 1'b0; end
            OWN_PPU: begin e.we = pw; e.oe = ~pw; m_addr = pa; m_din = pd; m_last_ppu = 1'b1; end
            default: begin e.we = 1'b0; e.oe = 1'b0; end
        endcase
        e.addr = m_addr;
        e.din  = m_din;
        m_busy = (e.owner == OWN_IDLE) ? 0 : m_busy + 1;
        exp_q.push_back(e);

        cur = e;
        for (int k = 0; k < int'(SL); k++) begin
            @(posedge clk);
            #1;
            mem_dout = (k == int'(RL)) ? rdata : ~rdata;
            if (k == 0) cur = exp_q.pop_front();
            if (k == int'(RL) + 1 && cur.oe) begin
                if (cur.owner == OWN_CPU) m_cpu_dout = rdata;
                if (cur.owner == OWN_PPU) m_ppu_dout = rdata;
            end
            ack_exp = 3'b000;
            if (k == int'(RL) + 1) begin
                ack_exp[2] = (cur.owner == OWN_DL);
                ack_exp[1] = (cur.owner == OWN_CPU);
                ack_exp[0] = (cur.owner == OWN_PPU);
            end
            check("start", 64'(mem_start), 64'(k == 0));
            check("cmd", 64'({mem_owner, mem_we, mem_oe, mem_addr, mem_din}),
                  64'({cur.owner, cur.we, cur.oe, cur.addr, cur.din}));
            check("acks", 64'({dl_ack, cpu_ack, ppu_ack}), 64'(ack_exp));
            check("douts", 64'({cpu_dout, ppu_dout}), 64'({m_cpu_dout, m_ppu_dout}));
        end
    endtask

    task automatic idle_slot();
        run_slot(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 8'h00);
    endtask

    initial begin
        reset = 1'b1;
        dl_req = 1'b0; dl_addr = '0; dl_din = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        ppu_req = 1'b0; ppu_we = 1'b0; ppu_addr = '0; ppu_din = '0;
        mem_dout = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b0;

        idle_slot();
        // single CPU read
        run_slot(1'b0, 1'b1, 1'b0, 25'h000123, 8'h00, 1'b0, 1'b0, '0, '0, 8'hA5);
        check("cpu_read_dout", 64'(cpu_dout), 64'h A5);
        idle_slot();

        // CPU and PPU contending; the fifth decision hits the refresh bound
        for (int i = 0; i < 5; i++)
            run_slot(1'b0, 1'b1, 1'b0, 25'h000200 + AW'(i), 8'h00,
                     1'b1, 1'b0, 25'h000300 + AW'(i), 8'h00, 8'h11 * 8'(i + 1));

        // loader preempts both, then drops after its ack
        dl_addr = 25'h1ABCDE;
        dl_din  = 8'h5A;
        run_slot(1'b1, 1'b1, 1'b0, 25'h000400, 8'h00, 1'b1, 1'b0, 25'h000500, 8'h00, 8'h77);
        for (int i = 0; i < 2; i++)
            run_slot(1'b0, 1'b1, 1'b0, 25'h000400, 8'h00, 1'b1, 1'b0, 25'h000500, 8'h00,
                     8'h80 + 8'(i));
        idle_slot();

        // refresh bound with a lone CPU requester
        for (int i = 0; i < 6; i++)
            run_slot(1'b0, 1'b1, 1'b0, 25'h000600, 8'h00, 1'b0, 1'b0, '0, '0, 8'hC0 + 8'(i));
        idle_slot();

        // PPU write leaves ppu_dout alone
        run_slot(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 25'h000456, 8'h3C, 8'hEE);
        check("ppu_write_din", 64'(mem_din), 64'h3C);
        idle_slot();

        // randomized mix
        for (int i = 0; i < 24; i++) begin
            dl_addr = AW'($urandom);
            dl_din  = 8'($urandom);
            run_slot($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), AW'($urandom),
                     8'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), 8'($urandom),
                     8'($urandom));
        end
        idle_slot();

        // reset in phase 3 of a CPU read abandons it
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h000789; ppu_req = 1'b0; dl_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(posedge clk);
        #1;
        check_reset_vals("midrst_hold");
        reset = 1'b0;
        model_reset();
        run_slot(1'b0, 1'b1, 1'b0, 25'h000789, 8'h00, 1'b0, 1'b0, '0, '0, 8'h9D);
        check("post_rst_dout", 64'(cpu_dout), 64'h9D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
